board_io_ctrl: RTL

Parametrised board-level I/O controller for the Nexys4-DDR top. It debounces N push-buttons and produces level and press-pulse outputs. It drives a time-multiplexed N-digit seven-segment display from a double-buffered hex/DP/enable image, and pages a wide status word onto the LED bank. It replaces ad-hoc LED/segment wiring at top level and connects to CPU-side GPIO registers.

---
 rtl/board_io_pkg.sv | 34 +++
 rtl/board_io_ctrl_if.sv | 12 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/board_io_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared constants and elaboration-time helpers for the board I/O controller:
// seven-segment glyph table and width/page-count arithmetic.
package board_io_pkg;

    // Glyphs are {G,F,E,D,C,B,A}, active low.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int cwidth(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    function automatic int num_pages(input int status_w, input int led_w);
        return (status_w + led_w - 1) / led_w;
    endfunction

    function automatic int page_w(input int status_w, input int led_w);
        return cwidth(num_pages(status_w, led_w));
    endfunction

endpackage

// File: rtl/board_io_ctrl_if.sv
// CPU-side display image bus: hex nibbles, decimal points, enables and a load strobe.
interface board_io_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_en;
    logic                    disp_load;

    modport master (output disp_data, output disp_dp, output disp_en, output disp_load);
    modport slave  (input  disp_data, input  disp_dp, input  disp_en, input  disp_load);
endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, stability counter, debounced level and
// a single-cycle press pulse the cycle after the level rises.
module btn_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);
    localparam int CNT_W = cwidth(DEBOUNCE_CYCLES);

    logic             meta_q, sync_q;
    logic             level_q, level_d, level_dly_q, press_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q      <= 1'b0;
            sync_q      <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            meta_q      <= raw_i;
            sync_q      <= meta_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced buttons, double-buffered multiplexed
// seven-segment scan with ghost blanking, and paged status LEDs.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int  NUM_BTNS        = 5,
    parameter int  DEBOUNCE_CYCLES = 1_000_000,
    parameter int  NUM_DIGITS      = 8,
    parameter int  DIGIT_CYCLES    = 12_500,
    parameter int  BLANK_CYCLES    = 250,
    parameter int  STATUS_W        = 32,
    parameter int  LED_W           = 16,
    parameter int  PAGE_BTN        = 1,
    localparam int PAGE_W          = page_w(STATUS_W, LED_W)
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESETN,
    input  logic [NUM_BTNS-1:0]   btn_raw,
    output logic [NUM_BTNS-1:0]   btn_level,
    output logic [NUM_BTNS-1:0]   btn_press,
    board_io_ctrl_if.slave        disp,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [6:0]            SEG,
    output logic                  DP,
    input  logic [STATUS_W-1:0]   status_in,
    output logic [LED_W-1:0]      LED,
    output logic [PAGE_W-1:0]     led_page
);
    localparam int SLOT_W    = cwidth(DIGIT_CYCLES);
    localparam int DIG_W     = cwidth(NUM_DIGITS);
    localparam int NUM_PAGES = num_pages(STATUS_W, LED_W);
    localparam int PAD_W     = NUM_PAGES * LED_W;

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i   (CLK100MHZ),
            .rst_ni  (CPU_RESETN),
            .raw_i   (btn_raw[b]),
            .level_o (btn_level[b]),
            .press_o (btn_press[b])
        );
    end

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic                    frame_wrap;
    logic [4*NUM_DIGITS-1:0] shd_data_q, act_data_q;
    logic [NUM_DIGITS-1:0]   shd_dp_q, act_dp_q, shd_en_q, act_en_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [PAGE_W-1:0]       page_q, page_d;
    logic [LED_W-1:0]        led_q, led_d;
    logic [PAD_W-1:0]        status_pad;

    always_comb begin
        slot_d     = slot_q + SLOT_W'(1);
        digit_d    = digit_q;
        frame_wrap = 1'b0;
        if (slot_q == SLOT_W'(DIGIT_CYCLES - 1)) begin
            slot_d = '0;
            if (digit_q == DIG_W'(NUM_DIGITS - 1)) begin
                digit_d    = '0;
                frame_wrap = 1'b1;
            end else begin
                digit_d = digit_q + DIG_W'(1);
            end
        end
    end

    // Leading blank cycles keep the previous digit's segments off the new anode.
    always_comb begin
        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (slot_q >= SLOT_W'(BLANK_CYCLES) && act_en_q[digit_q]) begin
            an_d  = ~(NUM_DIGITS'(1) << digit_q);
            seg_d = hex_to_seg(act_data_q[4*digit_q +: 4]);
            dp_d  = ~act_dp_q[digit_q];
        end
    end

    always_comb begin
        status_pad                 = '0;
        status_pad[STATUS_W-1:0]   = status_in;
        led_d                      = status_pad[LED_W*page_q +: LED_W];
        page_d                     = page_q;
        if (btn_press[PAGE_BTN]) begin
            page_d = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            slot_q     <= '0;
            digit_q    <= '0;
            // NOTE: the image buffers are reset so the display comes up dark, not with stale glyphs.
            shd_data_q <= '0;
            shd_dp_q   <= '0;
            shd_en_q   <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '0;
            an_q       <= '1;
            seg_q      <= '1;
            dp_q       <= 1'b1;
            page_q     <= '0;
            led_q      <= '0;
        end else begin
            slot_q  <= slot_d;
            digit_q <= digit_d;
            if (disp.disp_load) begin
                shd_data_q <= disp.disp_data;
                shd_dp_q   <= disp.disp_dp;
                shd_en_q   <= disp.disp_en;
            end
            // A load on the wrap edge lands in shadow too late; active takes the old shadow.
            if (frame_wrap) begin
                act_data_q <= shd_data_q;
                act_dp_q   <= shd_dp_q;
                act_en_q   <= shd_en_q;
            end
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            page_q <= page_d;
            led_q  <= led_d;
        end
    end

    assign AN       = an_q;
    assign SEG      = seg_q;
    assign DP       = dp_q;
    assign LED      = led_q;
    assign led_page = page_q;

endmodule
